// File: rtl/gprs_multiport.sv
// General-purpose register file: NRD combinational read ports with write bypass,
// one writeback port, one issue-side reserve port and a per-register busy scoreboard.
// Optional feature: define GPRS_R0_ZERO_EN to hardwire register 0 to zero.
module gprs_multiport #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = $clog2(NREGS),
    parameter int unsigned NRD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rs,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     ws,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [NREGS-1:0]      busy_vec
);

`ifdef GPRS_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy_next;
    logic              wr_ok;
    logic              rsv_ok;
    logic [ADDR_W-1:0] ra;

    // An address is live if it maps to a real register that is not the hardwired R0.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < (ADDR_W+1)'(NREGS));
        return in_range && !(R0_ZERO && (a == '0));
    endfunction

    assign wr_ok  = we && addr_ok(ws);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Scoreboard next state: writeback clears, reserve sets and wins on collision.
    always_comb begin
        busy_next = busy_vec;
        if (wr_ok) begin
            busy_next[ws] = 1'b0;
        end
        if (rsv_ok) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            busy_vec <= '0;
        end else begin
            if (wr_ok) begin
                regs[ws] <= wd;
            end
            busy_vec <= busy_next;
        end
    end

    // Zero-latency read ports; a same-cycle writeback bypasses data and releases the stall.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            ra = rs[k*ADDR_W +: ADDR_W];
            if (addr_ok(ra)) begin
                rd[k*DATA_W +: DATA_W] = (wr_ok && (ws == ra)) ? wd : regs[ra];
                rd_busy[k] = busy_vec[ra] &&
                             !(wr_ok && (ws == ra) && !(rsv_ok && (rsv_addr == ws)));
            end
        end
    end

endmodule

// File: tb/tb_gprs_multiport.sv
// Directed bench for gprs_multiport: default 16x8/2-port instance and a 32x6/3-port instance.
module tb_gprs_multiport;

`ifdef GPRS_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic [5:0]  rs_a;
    logic [31:0] rd_a;
    logic [1:0]  rd_busy_a;
    logic        we_a;
    logic [2:0]  ws_a;
    logic [15:0] wd_a;
    logic        rsv_en_a;
    logic [2:0]  rsv_addr_a;
    logic [7:0]  busy_vec_a;

    logic [8:0]  rs_b;
    logic [95:0] rd_b;
    logic [2:0]  rd_busy_b;
    logic        we_b;
    logic [2:0]  ws_b;
    logic [31:0] wd_b;
    logic        rsv_en_b;
    logic [2:0]  rsv_addr_b;
    logic [5:0]  busy_vec_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gprs_multiport u_dut_a (
        .clk(clk), .reset(reset),
        .rs(rs_a), .rd(rd_a), .rd_busy(rd_busy_a),
        .we(we_a), .ws(ws_a), .wd(wd_a),
        .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a),
        .busy_vec(busy_vec_a)
    );

    gprs_multiport #(.DATA_W(32), .NREGS(6), .NRD(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .rs(rs_b), .rd(rd_b), .rd_busy(rd_busy_b),
        .we(we_b), .ws(ws_b), .wd(wd_b),
        .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b),
        .busy_vec(busy_vec_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        we_a = 1'b0;
        rsv_en_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rs_a = '0; we_a = 1'b0; ws_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_addr_a = '0;
        rs_b = '0; we_b = 1'b0; ws_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_addr_b = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy_a", 32'(busy_vec_a), 32'h0);
        check("rst_rd_a", rd_a, 32'h0);
        check("rst_rdbusy_a", 32'(rd_busy_a), 32'h0);

        // 1 Reset: write R3, reserve R6, then reset clears both
        we_a = 1'b1; ws_a = 3'd3; wd_a = 16'hBEEF;
        rsv_en_a = 1'b1; rsv_addr_a = 3'd6;
        tick();
        idle_a();
        rs_a[2:0] = 3'd3;
        #1;
        check("pre_rst_rd3", 32'(rd_a[15:0]), 32'hBEEF);
        check("pre_rst_busy", 32'(busy_vec_a), 32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_rd3", 32'(rd_a[15:0]), 32'h0);
        check("post_rst_busy", 32'(busy_vec_a), 32'h0);

        // 2 Bypass
        we_a = 1'b1; ws_a = 3'd5; wd_a = 16'h1234;
        rs_a = {3'd5, 3'd5};
        #1;
        check("byp_rd0", 32'(rd_a[15:0]), 32'h1234);
        check("byp_rd1", 32'(rd_a[31:16]), 32'h1234);
        tick();
        idle_a();
        #1;
        check("byp_rd0_after", 32'(rd_a[15:0]), 32'h1234);
        check("byp_rd1_after", 32'(rd_a[31:16]), 32'h1234);

        // 3 Scoreboard
        rsv_en_a = 1'b1; rsv_addr_a = 3'd2;
        tick();
        idle_a();
        rs_a = {3'd5, 3'd2};
        #1;
        check("sb_busy0", 32'(rd_busy_a), 32'h1);
        check("sb_vec2", 32'(busy_vec_a), 32'h04);
        we_a = 1'b1; ws_a = 3'd2; wd_a = 16'h00AA;
        #1;
        check("sb_wb_busy0", 32'(rd_busy_a), 32'h0);
        check("sb_wb_rd0", 32'(rd_a[15:0]), 32'h00AA);
        tick();
        idle_a();
        #1;
        check("sb_vec_clear", 32'(busy_vec_a), 32'h0);
        check("sb_rd0_after", 32'(rd_a[15:0]), 32'h00AA);

        // 4 Collision on R4: reserve wins, data written
        rsv_en_a = 1'b1; rsv_addr_a = 3'd4;
        we_a = 1'b1; ws_a = 3'd4; wd_a = 16'h5555;
        rs_a = {3'd2, 3'd4};
        tick();
        idle_a();
        #1;
        check("col_vec", 32'(busy_vec_a), 32'h10);
        check("col_rd4", 32'(rd_a[15:0]), 32'h5555);
        check("col_rdbusy", 32'(rd_busy_a), 32'h1);
        // same-cycle writeback plus re-reserve keeps the stall
        rsv_en_a = 1'b1; rsv_addr_a = 3'd4;
        we_a = 1'b1; ws_a = 3'd4; wd_a = 16'h6666;
        #1;
        check("col2_rdbusy", 32'(rd_busy_a), 32'h1);
        check("col2_rd4", 32'(rd_a[15:0]), 32'h6666);
        tick();
        // different registers: reserve R1, write R4
        rsv_en_a = 1'b1; rsv_addr_a = 3'd1;
        we_a = 1'b1; ws_a = 3'd4; wd_a = 16'h7777;
        tick();
        idle_a();
        #1;
        check("diff_vec", 32'(busy_vec_a), 32'h02);
        check("diff_rd4", 32'(rd_a[15:0]), 32'h7777);

        // 5 R0 behaviour
        we_a = 1'b1; ws_a = 3'd0; wd_a = 16'hFFFF;
        rs_a = {3'd4, 3'd0};
        #1;
        check("r0_bypass", 32'(rd_a[15:0]), R0_ZERO ? 32'h0 : 32'hFFFF);
        tick();
        idle_a();
        #1;
        check("r0_rd", 32'(rd_a[15:0]), R0_ZERO ? 32'h0 : 32'hFFFF);
        rsv_en_a = 1'b1; rsv_addr_a = 3'd0;
        tick();
        idle_a();
        #1;
        check("r0_busy", 32'(busy_vec_a[0]), R0_ZERO ? 32'h0 : 32'h1);
        check("r0_rdbusy", 32'(rd_busy_a[0]), R0_ZERO ? 32'h0 : 32'h1);

        // 6 Parametrised instance: 32-bit, 6 registers, 3 read ports
        for (int i = 0; i < 6; i++) begin
            we_b = 1'b1; ws_b = 3'(i); wd_b = 32'(i + 1);
            tick();
        end
        we_b = 1'b0;
        rs_b = {3'd5, 3'd3, 3'd1};
        #1;
        check("p6_a_port0", rd_b[31:0], 32'd2);
        check("p6_a_port1", rd_b[63:32], 32'd4);
        check("p6_a_port2", rd_b[95:64], 32'd6);
        rs_b = {3'd4, 3'd2, 3'd0};
        #1;
        check("p6_b_port0", rd_b[31:0], R0_ZERO ? 32'd0 : 32'd1);
        check("p6_b_port1", rd_b[63:32], 32'd3);
        check("p6_b_port2", rd_b[95:64], 32'd5);
        // out-of-range write, reserve and read are all inert
        we_b = 1'b1; ws_b = 3'd7; wd_b = 32'hDEAD_BEEF;
        rsv_en_b = 1'b1; rsv_addr_b = 3'd7;
        rs_b = {3'd2, 3'd6, 3'd7};
        #1;
        check("p6_oor_rd", rd_b[31:0], 32'd0);
        check("p6_oor_rd6", rd_b[63:32], 32'd0);
        check("p6_oor_bypass_none", rd_b[95:64], 32'd3);
        tick();
        we_b = 1'b0; rsv_en_b = 1'b0;
        rsv_addr_b = 3'd3; rsv_en_b = 1'b1;
        tick();
        rsv_en_b = 1'b0;
        rs_b = {3'd3, 3'd6, 3'd7};
        #1;
        check("p6_oor_vec", 32'(busy_vec_b), 32'h08);
        check("p6_oor_rdbusy", 32'(rd_busy_b), 32'h4);
        check("p6_oor_rd_after", rd_b[31:0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
